// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of a single-port data memory.
// Supports per-port ownership locks bounded by LOCK_MAX and returns registered read data.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] adr0,
  input  logic [AW-1:0] adr1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic            g0, g1, expired;

  assign expired = (lock_cnt_q == CW'(LOCK_MAX));

  // An expired lock grants nothing in its last cycle so the owner never exceeds LOCK_MAX grants.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (req0 && req1) begin
            g0 = last_q;
            g1 = !last_q;
          end else begin
            g0 = req0;
            g1 = req1;
          end
        end
        OWN0:    g0 = req0 && !expired;
        OWN1:    g1 = req1 && !expired;
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_din = '0;
    if (g0) begin
      mem_we  = we0;
      mem_adr = adr0;
      mem_din = din0;
    end else if (g1) begin
      mem_we  = we1;
      mem_adr = adr1;
      mem_din = din1;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    if (g0) last_d = 1'b0;
    if (g1) last_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (g0 && lock0) begin
          state_d    = OWN0;
          lock_cnt_d = CW'(1);
        end else if (g1 && lock1) begin
          state_d    = OWN1;
          lock_cnt_d = CW'(1);
        end
      end
      OWN0: begin
        if (!lock0 || expired) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          if (lock0) last_d = 1'b0;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      OWN1: begin
        if (!lock1 || expired) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
          if (lock1) last_d = 1'b1;
        end else begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    rvalid0_d = g0 && !we0;
    rvalid1_d = g1 && !we1;
    rdata0_d  = rvalid0_d ? mem_dout : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_dout : rdata1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign gnt0    = g0;
  assign gnt1    = g1;
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule
